// File: rtl/ddf_pkg.sv
// ddf_pkg: shared DDF actor constants and the expander state encoding
// Contents: DDF_EXP_SW state width, DDF_WIDTH / DDF_WIDTH_NDA token width defaults,
//           ddf_exp_state_e with PICK=0, CHOICE=1, FETCH=2, LATCH=3, EMIT=4
package ddf_pkg;
  localparam int DDF_EXP_SW = 3;
  localparam int DDF_WIDTH = 32;
  localparam int DDF_WIDTH_NDA = 4;
  typedef enum logic [DDF_EXP_SW-1:0] {
    DDF_EXP_PICK   = 3'd0,
    DDF_EXP_CHOICE = 3'd1,
    DDF_EXP_FETCH  = 3'd2,
    DDF_EXP_LATCH  = 3'd3,
    DDF_EXP_EMIT   = 3'd4
  } ddf_exp_state_e;
endpackage

// File: rtl/ddf_1p_1f_expand.sv
// ddf_1p_1f_expand: DDF expander, reads count N then one data token, writes N output tokens
// Ports: ck/rst (async active-high), nda_empty/nda_data/nda_rd count FIFO,
//        in0_empty/in0_data/in0_rd data FIFO, out0_full/out0_wr/out0_data output FIFO
// Macro DDF_EXPAND_RAMP_EN: output k of a firing is data+k instead of a plain copy
module ddf_1p_1f_expand
  import ddf_pkg::*;
#(
  parameter int WIDTH = DDF_WIDTH,
  parameter int WIDTH_NDA = DDF_WIDTH_NDA
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic                 nda_empty,
  input  logic [WIDTH_NDA-1:0] nda_data,
  output logic                 nda_rd,
  input  logic                 in0_empty,
  input  logic [WIDTH-1:0]     in0_data,
  output logic                 in0_rd,
  input  logic                 out0_full,
  output logic                 out0_wr,
  output logic [WIDTH-1:0]     out0_data
);
  ddf_exp_state_e state, state_nx;
  logic [WIDTH_NDA-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] hold, hold_nx;
  logic emit_wr;
`ifdef DDF_EXPAND_RAMP_EN
  logic [WIDTH_NDA-1:0] idx, idx_nx;
  assign out0_data = hold + WIDTH'(idx);
`else
  assign out0_data = hold;
`endif
  assign emit_wr = (state == DDF_EXP_EMIT) && !out0_full;
  always_comb begin
    state_nx = DDF_EXP_PICK;
    cnt_nx = cnt;
    hold_nx = hold;
`ifdef DDF_EXPAND_RAMP_EN
    idx_nx = idx;
`endif
    nda_rd = 1'b0;
    in0_rd = 1'b0;
    out0_wr = 1'b0;
    case (state)
      DDF_EXP_PICK: begin
        nda_rd = !nda_empty;
        state_nx = nda_empty ? DDF_EXP_PICK : DDF_EXP_CHOICE;
      end
      // a zero count is consumed without touching in0
      DDF_EXP_CHOICE: begin
        state_nx = (nda_data == '0) ? DDF_EXP_PICK : DDF_EXP_FETCH;
        cnt_nx = (nda_data == '0) ? cnt : nda_data;
`ifdef DDF_EXPAND_RAMP_EN
        idx_nx = (nda_data == '0) ? idx : '0;
`endif
      end
      DDF_EXP_FETCH: begin
        in0_rd = !in0_empty;
        state_nx = in0_empty ? DDF_EXP_FETCH : DDF_EXP_LATCH;
      end
      DDF_EXP_LATCH: begin
        hold_nx = in0_data;
        state_nx = DDF_EXP_EMIT;
      end
      DDF_EXP_EMIT: begin
        out0_wr = emit_wr;
        cnt_nx = emit_wr ? cnt - WIDTH_NDA'(1) : cnt;
`ifdef DDF_EXPAND_RAMP_EN
        idx_nx = emit_wr ? idx + WIDTH_NDA'(1) : idx;
`endif
        state_nx = (emit_wr && cnt == WIDTH_NDA'(1)) ? DDF_EXP_PICK : DDF_EXP_EMIT;
      end
      default: state_nx = DDF_EXP_PICK;
    endcase
    // PICK decodes strobes from the flags alone, so reset must mask them explicitly
    if (rst) begin
      nda_rd = 1'b0;
      in0_rd = 1'b0;
      out0_wr = 1'b0;
    end
  end
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= DDF_EXP_PICK;
      cnt <= '0;
      hold <= '0;
`ifdef DDF_EXPAND_RAMP_EN
      idx <= '0;
`endif
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      hold <= hold_nx;
`ifdef DDF_EXPAND_RAMP_EN
      idx <= idx_nx;
`endif
    end
  end
endmodule
